// File: rtl/fcvt_s_w_seq.sv
// -----------------------------------------------------------------------------
// fcvt_s_w_seq
// Iterative integer-to-binary32 converter (FCVT.S.W / FCVT.S.WU).
// The operand is turned into sign + magnitude and then normalised one bit per
// clock until the top bit is set. After that it is rounded in a single cycle
// according to rm. This block does not produce denormals, NaN or
// overflow/underflow; the only exception it can raise is inexact.
//
// Ports
//   clk          in   1   clock, all state changes on the rising edge
//   rst          in   1   synchronous active-high reset; aborts any conversion
//   start        in   1   conversion request, sampled only in IDLE
//   a            in   32  integer operand
//   is_unsigned  in   1   1: a is unsigned (WU), 0: a is two's complement (W)
//   rm           in   2   00 RNE, 01 RTZ, 10 RDN, 11 RUP
//   busy         out  1   high in every state except IDLE
//   done         out  1   one-cycle pulse; s/NX are valid from this cycle on
//   s            out  32  binary32 result, held until the next done
//   NX           out  1   inexact flag for s, held together with s
//   dbg_state_o  out  2   current FSM state (IDLE=0, NORM=1, ROUND=2, DONE=3)
//
// Handshake: start is accepted only when busy=0, and the operands a,
// is_unsigned and rm are captured in that same cycle. A start seen while
// busy=1 has no effect. Each accepted start produces exactly one done pulse,
// unless rst arrives first. In the cycle that done is high, busy is also
// still high. A new start can be accepted in the very next cycle.
// -----------------------------------------------------------------------------
module fcvt_s_w_seq #(
  parameter int EXP_BIAS = 127,
  parameter int MANT_W   = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic        is_unsigned,
  input  logic [1:0]  rm,
  output logic        busy,
  output logic        done,
  output logic [31:0] s,
  output logic        NX,
  output logic [1:0]  dbg_state_o
);

  // Once the hidden bit sits at mag[31], the exponent must equal bias+31.
  localparam logic [7:0] EXP_INIT = 8'(EXP_BIAS + 31);
  // Index of the guard bit: it lies just below the stored mantissa field.
  localparam int G_IDX = 30 - MANT_W;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [1:0]  rm_q, rm_d;
  logic [31:0] s_q, s_d;
  logic        nx_q, nx_d;

  // ---------------------------------------------------------------------------
  // Operand conditioning for the IDLE capture. The negation is a 32-bit
  // operation, so 0x80000000 maps back to 0x80000000. That value is already
  // the correct magnitude 2^31 and only needs to be read as unsigned.
  // ---------------------------------------------------------------------------
  logic        in_sign;
  logic [31:0] in_mag;

  always_comb begin
    in_sign = ~is_unsigned & a[31];
    in_mag  = in_sign ? (~a + 32'd1) : a;
  end

  // ---------------------------------------------------------------------------
  // Rounding datapath. It is only meaningful in ROUND, when mag_q[31]=1.
  // ---------------------------------------------------------------------------
  logic [MANT_W-1:0] man;
  logic              guard;
  logic              sticky;
  logic              inx;
  logic              inc;
  logic [MANT_W:0]   man_sum;
  logic [MANT_W-1:0] man_rnd;
  logic [7:0]        exp_rnd;

  always_comb begin
    man    = mag_q[30 -: MANT_W];
    guard  = mag_q[G_IDX];
    sticky = |mag_q[G_IDX-1:0];
    inx    = guard | sticky;

    inc = 1'b0;
    case (rm_q)
      RM_RNE: inc = guard & (sticky | man[0]);
      RM_RTZ: inc = 1'b0;
      RM_RDN: inc = inx & sign_q;
      RM_RUP: inc = inx & ~sign_q;
      default: inc = 1'b0;
    endcase

    // A carry out of the mantissa leaves the field all zeros, which is
    // exactly 1.0 x 2^(exp+1). The largest exponent that can result is
    // bias+32 = 159, so this cannot overflow.
    man_sum = {1'b0, man} + {{MANT_W{1'b0}}, inc};
    man_rnd = man_sum[MANT_W-1:0];
    exp_rnd = exp_q + {7'd0, man_sum[MANT_W]};
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    rm_d    = rm_q;
    s_d     = s_q;
    nx_d    = nx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d = in_sign;
          mag_d  = in_mag;
          exp_d  = EXP_INIT;
          rm_d   = rm;
          if (in_mag == 32'd0) begin
            // Zero gives +0 in every rounding mode and skips normalisation.
            s_d     = 32'd0;
            nx_d    = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end
      end

      ST_NORM: begin
        // This state also spends one cycle confirming the top bit, so it
        // takes lz+1 cycles in total.
        if (!mag_q[31]) begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end else begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        s_d     = {sign_q, exp_rnd, man_rnd};
        nx_d    = inx;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mag_q   <= 32'd0;
      exp_q   <= 8'd0;
      sign_q  <= 1'b0;
      rm_q    <= 2'b00;
      s_q     <= 32'd0;
      nx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      rm_q    <= rm_d;
      s_q     <= s_d;
      nx_q    <= nx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    s           = s_q;
    NX          = nx_q;
    dbg_state_o = state_q;
  end

endmodule
